// File: rtl/ntru_hrss_pkg.sv
// Shared constants, FSM state encoding and trit conversion for the NTRU-HRSS
// encapsulation datapath.
package ntru_hrss_pkg;

   localparam int N_TRITS = 700;
   localparam int Q_BITS  = 13;
   localparam int Q       = 1 << Q_BITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } rm_state_t;

   // 2'b10 encodes -1, whose representative is q-1; the illegal 2'b11 maps to 0.
   function automatic logic [Q_BITS-1:0] trit_to_q(input logic [1:0] t);
      logic [Q_BITS-1:0] v;
      case (t)
         2'b01:   v = Q_BITS'(1);
         2'b10:   v = '1;
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/trit2q.sv
// One lane of trit-to-mod-q conversion with a flag for the illegal 2'b11 code.
module trit2q
   import ntru_hrss_pkg::*;
(
   input  logic [1:0]        trit_i,
   output logic [Q_BITS-1:0] coef_o,
   output logic              err_o
);

   assign coef_o = trit_to_q(trit_i);
   assign err_o  = (trit_i == 2'b11);

endmodule

// File: rtl/rm_stream.sv
// Captures the sampler's packed r/m trit vector and streams one (r, m) coefficient
// pair per accepted beat, padding both polynomials with a zero at index 700.
module rm_stream #(
   parameter int N_TRITS = 700,
   parameter int RM_BITS = 2800,
   parameter int Q_BITS  = 13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [RM_BITS-1:0] rm,
   input  logic               rm_done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [9:0]         out_idx,
   output logic [Q_BITS-1:0]  out_r,
   output logic [Q_BITS-1:0]  out_m,
   output logic               out_last,
   output logic               busy,
   output logic               finish,
   output logic               trit_err
);

   import ntru_hrss_pkg::*;

   localparam int         SR_BITS  = 2 * N_TRITS;
   localparam logic [9:0] LAST_IDX = 10'(N_TRITS);

   rm_state_t           state_q;
   logic                doneHist_q;
   logic [SR_BITS-1:0]  rSr_q;
   logic [SR_BITS-1:0]  mSr_q;
   logic                outValid_q;
   logic                outLast_q;
   logic                busy_q;
   logic                finish_q;
   logic                tritErr_q;
   logic [9:0]          outIdx_q;
   logic [Q_BITS-1:0]   outR_q;
   logic [Q_BITS-1:0]   outM_q;

   logic                doneRise;
   logic                capture;
   logic [9:0]          idxNext_d;
   logic                lastNext_d;
   logic [1:0]          tritR;
   logic [1:0]          tritM;
   logic [Q_BITS-1:0]   coefR;
   logic [Q_BITS-1:0]   coefM;
   logic                errR;
   logic                errM;
   logic                unusedRm0;

   // Bit 0 of the bus carries no trit; the top bit of m trit 699 would sit
   // past the bus end and is therefore read as 0.
   assign unusedRm0 = rm[0];

   assign doneRise  = rm_done & ~doneHist_q;
   assign capture   = (state_q == IDLE) & doneRise;
   assign idxNext_d  = outIdx_q + 10'd1;
   assign lastNext_d = (idxNext_d == LAST_IDX);

   // The shift registers always hold the trit of the next beat in bits [1:0].
   assign tritR = capture ? rm[2:1] : rSr_q[1:0];
   assign tritM = capture ? rm[2*N_TRITS+2:2*N_TRITS+1] : mSr_q[1:0];

   trit2q u_trit2q_r (
      .trit_i (tritR),
      .coef_o (coefR),
      .err_o  (errR)
   );

   trit2q u_trit2q_m (
      .trit_i (tritM),
      .coef_o (coefM),
      .err_o  (errM)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         doneHist_q <= 1'b0;
         rSr_q      <= '0;
         mSr_q      <= '0;
         outValid_q <= 1'b0;
         outLast_q  <= 1'b0;
         busy_q     <= 1'b0;
         finish_q   <= 1'b0;
         tritErr_q  <= 1'b0;
         outIdx_q   <= '0;
         outR_q     <= '0;
         outM_q     <= '0;
      end else begin
         doneHist_q <= rm_done;
         case (state_q)
            IDLE: begin
               if (capture) begin
                  state_q    <= STREAM;
                  busy_q     <= 1'b1;
                  outValid_q <= 1'b1;
                  outLast_q  <= 1'b0;
                  outIdx_q   <= '0;
                  rSr_q      <= {2'b00, rm[2*N_TRITS:3]};
                  mSr_q      <= {3'b000, rm[RM_BITS-1:2*N_TRITS+3]};
                  outR_q     <= coefR;
                  outM_q     <= coefM;
                  tritErr_q  <= errR | errM;
               end
            end
            STREAM: begin
               if (out_ready) begin
                  if (outLast_q) begin
                     state_q    <= DONE;
                     outValid_q <= 1'b0;
                     outLast_q  <= 1'b0;
                     busy_q     <= 1'b0;
                     finish_q   <= 1'b1;
                  end else begin
                     rSr_q     <= {2'b00, rSr_q[SR_BITS-1:2]};
                     mSr_q     <= {2'b00, mSr_q[SR_BITS-1:2]};
                     outIdx_q  <= idxNext_d;
                     outLast_q <= lastNext_d;
                     outR_q    <= lastNext_d ? '0 : coefR;
                     outM_q    <= lastNext_d ? '0 : coefM;
                     tritErr_q <= tritErr_q | (~lastNext_d & (errR | errM));
                  end
               end
            end
            DONE: begin
               // Waiting for rm_done to fall keeps a held-high level from restarting.
               if (!rm_done) begin
                  state_q  <= IDLE;
                  finish_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = outValid_q;
   assign out_last  = outLast_q;
   assign busy      = busy_q;
   assign finish    = finish_q;
   assign trit_err  = tritErr_q;
   assign out_idx   = outIdx_q;
   assign out_r     = outR_q;
   assign out_m     = outM_q;

endmodule

// File: doc/rm_stream.md
# rm_stream

Downstream stage of the ternary sampler in the NTRU-HRSS encapsulation datapath. It captures the packed 2800-bit `rm` vector once the sampler raises `done`, then streams r and m coefficients one index per beat into the polynomial multiplier. Each 2-bit trit is converted to its 13-bit mod-q representative, and the beats are carried on a valid/ready handshake.

## Interface
Parameters:
- `N_TRITS`, 700: trits per polynomial, for both r and m.
- `RM_BITS`, 2800: width of the packed input, equal to 4·`N_TRITS`.
- `Q_BITS`, 13: coefficient width; q = 2^`Q_BITS` = 8192.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rm`  in  `RM_BITS`  packed trits from the sampler; stable while `rm_done` is high.
- `rm_done`  in  1  sampler completion level.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts the beat.
- `out_idx`  out  10  coefficient index, 0..700.
- `out_r`  out  `Q_BITS`  r coefficient mod q.
- `out_m`  out  `Q_BITS`  m coefficient mod q.
- `out_last`  out  1  high on the beat with index 700.
- `busy`  out  1  high in STREAM.
- `finish`  out  1  high in DONE.
- `trit_err`  out  1  sticky flag: an encoding of 2'b11 was seen.

## Operation
Packing:
- r coefficient i occupies `rm[2i+2:2i+1]`.
- m coefficient i occupies `rm[1400+2i+2:1400+2i+1]`.

Trit to mod-q conversion:
- 0 → 0.
- 1 → 1.
- 2 → 8191 (q−1).
- 3 → 0, and sets `trit_err`.

Index 700 always emits r = m = 0, padding each polynomial to n = 701 coefficients.

State machine:
- IDLE → STREAM on a rising edge of `rm_done`, detected with a one-flop history. The same edge copies `rm` into an internal shift register and clears `out_idx` and `trit_err`.
- STREAM: the current beat is held on the outputs. Each accepted beat (`out_valid` && `out_ready`) shifts the register down by one trit per polynomial and increments `out_idx`.
- STREAM → DONE on acceptance of the beat with `out_last` high.
- DONE → IDLE when `rm_done` is low. This prevents a held-high `rm_done` from retriggering.

Edge cases:
- A `rm_done` rising edge seen while in STREAM or DONE is ignored.
- While `out_ready` is low, all outputs hold stable; valid is never retracted.
- `trit_err` is sticky until the next capture or reset.

## Timing
- Reset values: `out_valid`, `out_last`, `busy`, `finish` and `trit_err` are 0; `out_idx`, `out_r` and `out_m` are 0; state is IDLE; the edge-history flop is 0.
- Capture edge E, at which `rm_done` is sampled 1 after being sampled 0: state is STREAM and `out_valid` = 1 from E+1. The beat-0 data is registered and valid in that same cycle.
- With `out_ready` held at 1, one beat is accepted per cycle. Beats 0..700 occupy cycles E+1..E+701.
- DONE (`finish` = 1) begins at E+702.
- Output registers update only on an accepting edge. Next-beat data is computed combinationally from the shifted register, so there are no bubbles.
- Reset asserted mid-stream clears everything immediately, and asynchronously; no partial beat is emitted after reset releases.
- IDLE is the first state in which a new capture is possible. The earliest capture is one cycle after `rm_done` is sampled low in DONE.

## Structure
Package `ntru_hrss_pkg`:
- Constants `N_TRITS`, `Q_BITS`, `Q`.
- Enum `rm_state_t` {IDLE, STREAM, DONE}.
- Function `trit_to_q(logic [1:0]) → logic [Q_BITS-1:0]`.

Sub-module `trit2q`:
- Combinational converter, instantiated twice (one for r, one for m).
- Outputs the mod-q value plus a per-lane error bit.
- The top block holds the FSM, the edge detector, the 1400-bit r/m shift registers, the index counter and the output registers.

## Test plan
- All r trits = 1, all m trits = 2, `out_ready` = 1, pulse `rm_done` → 701 beats with indices 0..700 back-to-back:
  - beats 0..699: r = 1, m = 8191;
  - beat 700: r = m = 0 with `out_last` = 1;
  - `finish` = 1 at E+702.
- Incrementing pattern (r_i = i mod 3, m_i = (i+1) mod 3) with `out_ready` randomly toggled → beat sequence matches the model exactly; outputs stay stable while `out_ready` is low.
- r coefficient 5 encoded as 2'b11 → beat 5 has r = 0; `trit_err` is 1 from that beat until the next capture.
- `rm_done` held high through DONE, then dropped, then raised again → exactly one stream per rising edge; no retrigger while high.
- Reset driven low at beat 300 → all outputs 0 and state IDLE immediately. A fresh `rm_done` edge afterwards restarts at index 0 with the new `rm`.
- `rm_done` pulsed again mid-stream (at beat 100) → ignored; the stream continues to 700 unchanged.
